memory_interface_unit: RTL
==========================

Name: memory_interface_unit

Overview:
Memory subsystem directly downstream of the control unit. It consumes the control unit's MARin, MDRin, Read and Write strobes, holds MAR and MDR, and runs a fixed-latency handshake against an internal word-addressed RAM. MDR_q feeds the bus multiplexer, and Done/Busy let the control unit stall its memory states (ld, st, fetch) until the access completes.

Parameters:
DATA_WIDTH, 32, width of bus, MDR and RAM words
ADDR_WIDTH, 9, MAR width; RAM depth = 2**ADDR_WIDTH words (512)
MEM_LATENCY, 2, clock edges from request acceptance to access completion; legal range 1..15

Ports:
Clock  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-high reset
BusMuxOut  input  DATA_WIDTH  internal CPU bus
MARin  input  1  load MAR from BusMuxOut[ADDR_WIDTH-1:0]
MDRin  input  1  load MDR from BusMuxOut (bus path only)
Read  input  1  memory read request (level)
Write  input  1  memory write request (level)
MAR_q  output  ADDR_WIDTH  current MAR
MDR_q  output  DATA_WIDTH  current MDR, to bus mux
Busy  output  1  access in flight
Done  output  1  one-cycle pulse on access completion

Behaviour:
- Reset (async, active-high): MAR_q=0, MDR_q=0, Busy=0, Done=0, state=IDLE, armed=1, counter=0. RAM contents are preserved. An in-flight write is aborted and never committed.
- MAR: MAR_q <= BusMuxOut[ADDR_WIDTH-1:0] on any edge with MARin=1, in any state. Upper bus bits are dropped, so addresses wrap modulo 512.
- MDR bus load: MDR_q <= BusMuxOut on an edge with MDRin=1, except in RD_WAIT, where the bus load is ignored.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE → RD_WAIT: on an edge with Read=1 and armed=1. Latch addr=MAR_q, counter=MEM_LATENCY-1, clear armed.
- IDLE → WR_WAIT: on an edge with Write=1, Read=0 and armed=1. Latch addr=MAR_q and data=MDR_q, counter=MEM_LATENCY-1, clear armed.
- Read and Write both high in IDLE: read wins and the write is dropped.
- Latched address: a MARin during a transaction updates MAR_q but does not affect the latched address.
- Latched write data: an MDRin during WR_WAIT updates MDR_q, but the write uses the latched data.
- RD_WAIT/WR_WAIT, counter≠0: decrement the counter each edge.
- RD_WAIT/WR_WAIT, counter=0: on that edge, RD_WAIT does MDR_q <= RAM[addr]; WR_WAIT does RAM[addr] <= data. Then go to IDLE with Done=1.
- Latency: request accepted at edge k; access occurs at edge k+MEM_LATENCY; Done is high for exactly the one cycle after that edge.
- Busy is high in RD_WAIT and WR_WAIT, low in IDLE. Busy and Done are registered outputs.
- Re-arm rule: armed is set on any edge where Read=0 and Write=0. A request held high past Done therefore never retriggers; the control unit must drop Read/Write for at least one edge between accesses.
- Requests that change during RD_WAIT/WR_WAIT are ignored; no queueing.
- Back-to-back: the earliest next acceptance is the edge after Done, provided the requests were low at the Done edge.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults
  - memory FSM state encodings: IDLE=2'd0, RD_WAIT=2'd1, WR_WAIT=2'd2
  - the MEM_LATENCY default
- One sub-module, mem_ram: single-port synchronous RAM with one write port and a registered read, depth 2**ADDR_WIDTH.
  - Write takes effect on the write-enable edge.
  - Read data is valid in the cycle after its enable.
- The FSM issues the mem_ram read enable one edge before the counter=0 edge (MEM_LATENCY=1: on the acceptance edge), so the data is available at the completion edge.
- The FSM, counter and MAR/MDR stay in memory_interface_unit.

Test Plan:
- Reset mid-write: MAR=0x10, MDR=0xDEADBEEF, Write=1, assert Reset one cycle after acceptance → MAR_q=0, MDR_q=0, Busy=0, Done never pulses; a later read of 0x10 returns the prior contents.
- Write then read, MEM_LATENCY=2: MARin with bus=0x0000_0055, MDRin with bus=0x1234_5678, Write=1 → Busy for 2 cycles, Done pulse, Write low; then Read=1 → Done two edges after acceptance and MDR_q=0x1234_5678.
- Address wrap: MARin with bus=0x0000_0205 → MAR_q=0x005; read returns the word written at 0x005.
- Held request: Read held high for 8 cycles → exactly one Done pulse; lowering Read for one cycle and raising it again → a second Done.
- Simultaneous Read+Write in IDLE at addr 0x20 (contents 0xA5A5A5A5, MDR=0x11111111) → read performed, MDR_q=0xA5A5A5A5, RAM[0x20] unchanged.
- Interference: during WR_WAIT, MARin bus=0x30 and MDRin bus=0x99 → the write lands at the originally latched address with the originally latched data; MAR_q=0x30 and MDR_q=0x99 afterwards.
- Bus load during read: during RD_WAIT, MDRin bus=0x77 → ignored; MDR_q equals the RAM word at completion.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, memory-FSM state encodings and default access latency
// for the CPU datapath blocks.
package cpu_pkg;

   localparam int CPU_DATA_WIDTH  = 32;
   localparam int CPU_ADDR_WIDTH  = 9;
   localparam int CPU_MEM_LATENCY = 2;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] WR_WAIT = 2'd2;

endpackage

// File: rtl/mem_ram.sv
// Single-port synchronous RAM: write lands on the enable edge, read data is
// registered and valid the cycle after its enable. Contents have no reset.
module mem_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_interface_unit.sv
// MAR/MDR holding registers plus a fixed-latency request/complete handshake
// against the internal word RAM; Busy/Done let the control unit stall.
//
// state   | meaning
// IDLE    | no access in flight; accepts Read/Write when armed
// RD_WAIT | read in flight; counter runs down, MDR loads RAM word at zero
// WR_WAIT | write in flight; counter runs down, latched data written at zero
module memory_interface_unit
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH  = CPU_DATA_WIDTH,
   parameter int ADDR_WIDTH  = CPU_ADDR_WIDTH,
   parameter int MEM_LATENCY = CPU_MEM_LATENCY
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [DATA_WIDTH-1:0] BusMuxOut,
   input  logic                  MARin,
   input  logic                  MDRin,
   input  logic                  Read,
   input  logic                  Write,
   output logic [ADDR_WIDTH-1:0] MAR_q,
   output logic [DATA_WIDTH-1:0] MDR_q,
   output logic                  Busy,
   output logic                  Done
);

   localparam int CW = 4;
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  armed_q, armed_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [ADDR_WIDTH-1:0] mar_d;
   logic [DATA_WIDTH-1:0] mdr_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  ram_we, ram_re;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   logic accept_rd, accept_wr;

   assign accept_rd = (state_q == IDLE) && Read && armed_q;
   assign accept_wr = (state_q == IDLE) && Write && !Read && armed_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      armed_d  = armed_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      mar_d    = MARin ? BusMuxOut[ADDR_WIDTH-1:0] : MAR_q;
      mdr_d    = MDR_q;
      done_d   = 1'b0;
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      ram_addr = addr_q;

      if (MDRin && (state_q != RD_WAIT)) mdr_d = BusMuxOut;
      if (!Read && !Write) armed_d = 1'b1;

      case (state_q)
         IDLE: begin
            ram_addr = MAR_q;
            if (accept_rd) begin
               state_d = RD_WAIT;
               addr_d  = MAR_q;
               cnt_d   = CNT_INIT;
               armed_d = 1'b0;
               // With single-cycle latency the read must launch now.
               ram_re  = (MEM_LATENCY == 1);
            end else if (accept_wr) begin
               state_d = WR_WAIT;
               addr_d  = MAR_q;
               wdata_d = MDR_q;
               cnt_d   = CNT_INIT;
               armed_d = 1'b0;
            end
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               mdr_d   = ram_rdata;
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d  = cnt_q - 1'b1;
               ram_re = (cnt_q == CW'(1));
            end
         end
         WR_WAIT: begin
            if (cnt_q == '0) begin
               ram_we  = 1'b1;
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         armed_q <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         MAR_q   <= '0;
         MDR_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         MAR_q   <= mar_d;
         MDR_q   <= mdr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;

   mem_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk_i   (Clock),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

endmodule
